// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered, time-multiplexed four-digit common-anode 7-segment driver
module seg7_scan_driver #(
   parameter int SCAN_DIV = 1,
   parameter int BLANK_LZ = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [15:0] wdata,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame_done,
   output logic        pending
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

   logic [PW-1:0] prescaler;
   logic [1:0]    digit;
   logic [15:0]   pend_data;
   logic [15:0]   disp_data;
   logic [3:0]    pend_dp;
   logic [3:0]    disp_dp;
   logic          tick;
   logic          boundary;
   logic [3:0]    nibble;
   logic [6:0]    hex;
   logic          blank;
   logic [3:0]    an_d;
   logic [7:0]    seg_d;

   assign tick     = (prescaler == PS_MAX);
   assign boundary = tick && (digit == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         digit     <= 2'd0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick)
            digit <= digit + 2'd1;
      end
   end

   // The display buffer only ever changes at a frame boundary, so no digit mixes old and new data.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_data  <= 16'h0000;
         pend_dp    <= 4'h0;
         disp_data  <= 16'h0000;
         disp_dp    <= 4'h0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (boundary && pending) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
         end
         if (we) begin
            pend_data <= wdata;
            pend_dp   <= dp_in;
            pending   <= 1'b1;
         end else if (boundary) begin
            pending <= 1'b0;
         end
      end
   end

   always_comb begin
      nibble = 4'(disp_data >> {digit, 2'b00});
      case (nibble)
         4'h0: hex = 7'b1000000;
         4'h1: hex = 7'b1111001;
         4'h2: hex = 7'b0100100;
         4'h3: hex = 7'b0110000;
         4'h4: hex = 7'b0011001;
         4'h5: hex = 7'b0010010;
         4'h6: hex = 7'b0000010;
         4'h7: hex = 7'b1111000;
         4'h8: hex = 7'b0000000;
         4'h9: hex = 7'b0010000;
         4'hA: hex = 7'b0001000;
         4'hB: hex = 7'b0000011;
         4'hC: hex = 7'b1000110;
         4'hD: hex = 7'b0100001;
         4'hE: hex = 7'b0000110;
         default: hex = 7'b0001110;
      endcase
   end

   // A digit is a leading zero when it and every more-significant nibble are zero; digit 0 always shows.
   always_comb begin
      blank = 1'b0;
      if (BLANK_LZ != 0) begin
         case (digit)
            2'd1:    blank = (disp_data[15:4] == 12'h000);
            2'd2:    blank = (disp_data[15:8] == 8'h00);
            2'd3:    blank = (disp_data[15:12] == 4'h0);
            default: blank = 1'b0;
         endcase
      end
   end

   always_comb begin
      an_d  = ~(4'b0001 << digit);
      seg_d = {~disp_dp[digit], hex};
      if (blank) begin
         an_d  = 4'b1111;
         seg_d = 8'hFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an  <= 4'b1111;
         seg <= 8'hFF;
      end else begin
         an  <= an_d;
         seg <= seg_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a frame-level reference model
module tb_seg7_scan_driver;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [15:0] wdata = 16'h0000;
   logic [3:0]  dp_in = 4'h0;

   logic [3:0] an_w   [NI];
   logic [7:0] seg_w  [NI];
   logic       fd_w   [NI];
   logic       pend_w [NI];

   int sd [NI] = '{1, 3, 1};
   int bl [NI] = '{0, 0, 1};

   logic [6:0] lut [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int          cyc       [NI];
   logic [15:0] m_pend    [NI];
   logic [15:0] m_disp    [NI];
   logic [3:0]  m_pdp     [NI];
   logic [3:0]  m_ddp     [NI];
   logic        m_pending [NI];
   logic [3:0]  e_an      [NI];
   logic [7:0]  e_seg     [NI];
   logic        e_fd      [NI];
   bit          mvalid = 1'b0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.SCAN_DIV(1), .BLANK_LZ(0)) dut_a (
      .clk(clk), .reset(reset), .we(we), .wdata(wdata), .dp_in(dp_in),
      .an(an_w[0]), .seg(seg_w[0]), .frame_done(fd_w[0]), .pending(pend_w[0]));

   seg7_scan_driver #(.SCAN_DIV(3), .BLANK_LZ(0)) dut_b (
      .clk(clk), .reset(reset), .we(we), .wdata(wdata), .dp_in(dp_in),
      .an(an_w[1]), .seg(seg_w[1]), .frame_done(fd_w[1]), .pending(pend_w[1]));

   seg7_scan_driver #(.SCAN_DIV(1), .BLANK_LZ(1)) dut_c (
      .clk(clk), .reset(reset), .we(we), .wdata(wdata), .dp_in(dp_in),
      .an(an_w[2]), .seg(seg_w[2]), .frame_done(fd_w[2]), .pending(pend_w[2]));

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [11:0] disp_out(input int k, input int d,
                                            input logic [15:0] v, input logic [3:0] dp);
      logic [3:0] a;
      logic [3:0] nib;
      if (bl[k] != 0 && d >= 1 && (v >> (4 * d)) == 16'd0)
         return 12'hFFF;
      a    = 4'hF;
      a[d] = 1'b0;
      nib  = 4'((v >> (4 * d)) & 16'h000F);
      return {a, ~dp[d], lut[nib]};
   endfunction

   // Digit slot and frame position follow from the cycle count since reset released.
   task automatic model_step();
      int          d;
      bit          bnd;
      logic [11:0] o;
      for (int k = 0; k < NI; k++) begin
         if (reset) begin
            cyc[k] = 0;
            m_pend[k] = 16'h0; m_disp[k] = 16'h0;
            m_pdp[k] = 4'h0;   m_ddp[k] = 4'h0;
            m_pending[k] = 1'b0;
            e_an[k] = 4'hF; e_seg[k] = 8'hFF; e_fd[k] = 1'b0;
         end else begin
            d   = (cyc[k] / sd[k]) % 4;
            bnd = (cyc[k] % (4 * sd[k])) == (4 * sd[k] - 1);
            o   = disp_out(k, d, m_disp[k], m_ddp[k]);
            e_an[k]  = o[11:8];
            e_seg[k] = o[7:0];
            e_fd[k]  = bnd;
            if (bnd && m_pending[k]) begin
               m_disp[k] = m_pend[k];
               m_ddp[k]  = m_pdp[k];
               m_pending[k] = 1'b0;
            end
            if (we) begin
               m_pend[k] = wdata;
               m_pdp[k]  = dp_in;
               m_pending[k] = 1'b1;
            end
            cyc[k]++;
         end
      end
      mvalid = 1'b1;
   endtask

   task automatic cyc_t(input logic r, input logic w, input logic [15:0] d, input logic [3:0] p);
      reset = r; we = w; wdata = d; dp_in = p;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      cyc_t(1'b0, 1'b0, 16'h0000, 4'h0);
   endtask

   task automatic wait_fd();
      int n = 0;
      while (fd_w[0] !== 1'b1 && n < 20) begin
         idle();
         n++;
      end
      chk("frame_done_wait", {15'd0, fd_w[0]}, 16'd1);
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("model_an[%0d]", k),      {12'd0, an_w[k]},  {12'd0, e_an[k]});
            chk($sformatf("model_seg[%0d]", k),     {8'd0, seg_w[k]},  {8'd0, e_seg[k]});
            chk($sformatf("model_fd[%0d]", k),      {15'd0, fd_w[k]},  {15'd0, e_fd[k]});
            chk($sformatf("model_pending[%0d]", k), {15'd0, pend_w[k]}, {15'd0, m_pending[k]});
         end
      end
   end

   logic [7:0] exp1   [4] = '{8'h8E, 8'h80, 8'h08, 8'hF9};
   logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
   logic [7:0] exp_bl [4] = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};

   initial begin
      logic [31:0] rv;
      logic        rr;
      logic        rw;

      repeat (3) cyc_t(1'b1, 1'b0, 16'h0000, 4'h0);
      chk("reset_an",      {12'd0, an_w[0]}, 16'h000F);
      chk("reset_seg",     {8'd0, seg_w[0]}, 16'h00FF);
      chk("reset_pending", {15'd0, pend_w[0]}, 16'd0);
      chk("reset_fd",      {15'd0, fd_w[0]}, 16'd0);

      idle();
      chk("first_an",   {12'd0, an_w[0]}, 16'h000E);
      chk("first_seg",  {8'd0, seg_w[0]}, 16'h00C0);
      chk("first_an_b", {12'd0, an_w[1]}, 16'h000E);

      cyc_t(1'b0, 1'b1, 16'h1A8F, 4'b0100);
      chk("write_pending", {15'd0, pend_w[0]}, 16'd1);
      wait_fd();
      chk("load_pending_clear", {15'd0, pend_w[0]}, 16'd0);
      for (int i = 0; i < 4; i++) begin
         idle();
         chk($sformatf("1a8f_an%0d", i), {12'd0, an_w[0]}, {12'd0, ~(4'b0001 << i)});
         chk($sformatf("1a8f_seg%0d", i), {8'd0, seg_w[0]}, {8'd0, exp1[i]});
      end

      cyc_t(1'b0, 1'b1, 16'h1111, 4'h0);
      cyc_t(1'b0, 1'b1, 16'h2222, 4'h0);
      wait_fd();
      for (int i = 0; i < 4; i++) begin
         idle();
         chk($sformatf("overwrite_seg%0d", i), {8'd0, seg_w[0]}, 16'h00A4);
      end

      cyc_t(1'b0, 1'b1, 16'h5555, 4'h0);
      idle();
      idle();
      cyc_t(1'b0, 1'b1, 16'h3333, 4'h0);
      chk("same_cycle_fd",      {15'd0, fd_w[0]}, 16'd1);
      chk("same_cycle_pending", {15'd0, pend_w[0]}, 16'd1);
      for (int i = 0; i < 4; i++) begin
         idle();
         chk($sformatf("same_cycle_5_seg%0d", i), {8'd0, seg_w[0]}, 16'h0092);
      end
      chk("same_cycle_pending_after", {15'd0, pend_w[0]}, 16'd0);
      for (int i = 0; i < 4; i++) begin
         idle();
         chk($sformatf("same_cycle_3_seg%0d", i), {8'd0, seg_w[0]}, 16'h00B0);
      end

      cyc_t(1'b0, 1'b1, 16'h0070, 4'h0);
      wait_fd();
      for (int i = 0; i < 4; i++) begin
         idle();
         chk($sformatf("blank_an%0d", i),  {12'd0, an_w[2]}, {12'd0, exp_an[i]});
         chk($sformatf("blank_seg%0d", i), {8'd0, seg_w[2]}, {8'd0, exp_bl[i]});
      end

      idle();
      cyc_t(1'b0, 1'b1, 16'hABCD, 4'hF);
      cyc_t(1'b1, 1'b0, 16'h0000, 4'h0);
      chk("midreset_an",      {12'd0, an_w[0]}, 16'h000F);
      chk("midreset_seg",     {8'd0, seg_w[0]}, 16'h00FF);
      chk("midreset_pending", {15'd0, pend_w[1]}, 16'd0);
      idle();
      chk("midreset_seg_after", {8'd0, seg_w[0]}, 16'h00C0);
      chk("midreset_an_after",  {12'd0, an_w[0]}, 16'h000E);

      for (int n = 0; n < 3000; n++) begin
         rv = $urandom;
         rr = ($urandom_range(0, 299) == 0);
         rw = ($urandom_range(0, 3) == 0);
         cyc_t(rr, rw, rv[15:0], rv[19:16]);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
